hazard_ctrl_unit: RTL and testbench
===================================

# hazard_ctrl_unit

Pipeline hazard controller that sequences the IF/ID pipeline register, the PC and the ID/EX register. It detects load-use hazards between the ID and EX stages, squashes wrong-path instructions on taken branches and jumps, and freezes the front end while data memory is busy. It drives the `stall_flush` and `flush` controls of the IF/ID register and counts stall and flush events for performance inspection.

## Interface
- `FLUSH_CYCLES`, default 1: number of consecutive cycles IF/ID is flushed after a taken branch (1..4).
- `CNT_W`, default 16: width of the performance counters.
- `clk` in 1: the single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-low; forces reset state immediately.
- `Rs_ID` in 5: source register 1 of the instruction in ID.
- `Rt_ID` in 5: source register 2 of the instruction in ID.
- `Rd_EX` in 5: destination register of the instruction in EX.
- `MemRead_EX` in 1: the EX instruction is a load.
- `branch_taken_EX` in 1: a branch resolved taken in EX this cycle.
- `jump_ID` in 1: the ID instruction is an unconditional jump.
- `mem_busy` in 1: data memory cannot complete this cycle.
- `stall_flush` out 1: IF/ID hold.
- `flush` out 1: IF/ID clear.
- `pc_write_en` out 1: PC update enable.
- `id_ex_bubble` out 1: load a NOP into ID/EX.
- `stall_cnt` out CNT_W: saturating count of stall cycles.
- `flush_cnt` out CNT_W: saturating count of flush cycles.

## Operation
- FSM states: RUN, FLUSH, MEM_WAIT. Reset state is RUN. Reset clears `flush_left`, `pending_flush` and both counters to 0.
- Outputs are combinational from the current state and inputs. During reset every output is 0, except `pc_write_en`, which is 1.
- `load_use` = `MemRead_EX` & (`Rd_EX` != 0) & (`Rd_EX` == `Rs_ID` | `Rd_EX` == `Rt_ID`).
- Decision priority in RUN, highest first:
  1. `mem_busy`
     - Outputs: `stall_flush`=1, `pc_write_en`=0, `id_ex_bubble`=0.
     - Next state MEM_WAIT. If `branch_taken_EX` is also high, set `pending_flush`.
  2. `branch_taken_EX`
     - Outputs: `flush`=1, `id_ex_bubble`=1, `pc_write_en`=1.
     - If FLUSH_CYCLES>1, go to FLUSH with `flush_left`=FLUSH_CYCLES-1.
  3. `jump_ID`
     - Outputs: `flush`=1, `pc_write_en`=1, `id_ex_bubble`=0.
     - Exactly one cycle; state stays RUN.
  4. `load_use`
     - Outputs: `stall_flush`=1, `pc_write_en`=0, `id_ex_bubble`=1.
     - State stays RUN. The hazard clears on its own next cycle.
  5. Otherwise: all controls inactive, `pc_write_en`=1.
- FLUSH state:
  - Outputs: `flush`=1, `id_ex_bubble`=1, `pc_write_en`=1.
  - Decrement `flush_left`; return to RUN when it reaches 0.
  - `mem_busy` in FLUSH moves to MEM_WAIT with `pending_flush` set. The remaining flush cycles are dropped except the one replay.
- MEM_WAIT state:
  - Hold outputs as for `mem_busy`.
  - When `mem_busy` falls: if `pending_flush`, emit one flush cycle (as for `branch_taken_EX`) and clear `pending_flush`; otherwise go to RUN. Inputs are re-evaluated in the same cycle.
- Invariant: `stall_flush` and `flush` are never both 1. The IF/ID register ignores `flush` while held.
- Counters:
  - `stall_cnt` increments on every cycle with `stall_flush`=1.
  - `flush_cnt` increments on every cycle with `flush`=1.
  - Both saturate at all-ones and never wrap.

## Timing
- Hazard response has zero latency: controls assert in the same cycle the condition is visible and take effect at the next posedge.
- A load-use hazard costs exactly 1 stall cycle.
- A taken branch costs FLUSH_CYCLES flush cycles.
- A jump costs 1 flush cycle.
- `mem_busy` high for K cycles gives K stall cycles, plus 1 flush cycle if a branch was pending.
- Simultaneous branch and load-use: flush wins; no stall is issued and `stall_cnt` does not increment.
- Reset asserted mid-FLUSH or mid-MEM_WAIT: immediate return to RUN, and `pending_flush` is lost.
- Counters update at the posedge that ends the counted cycle.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the state enum;
  - `REG_ADDR_W`=5;
  - `REG_ZERO`=5'd0.
- One natural sub-module: `sat_counter` (parameterised width, increment enable, async active-low reset), instantiated twice.

## Test plan
- Load-use: `MemRead_EX`=1, `Rd_EX`=5, `Rs_ID`=5 for 1 cycle.
  - Expect `stall_flush`=1, `pc_write_en`=0, `id_ex_bubble`=1 for 1 cycle.
  - Expect `stall_cnt`=1.
- Zero register: `MemRead_EX`=1, `Rd_EX`=0, `Rt_ID`=0.
  - Expect no stall; all controls 0, `pc_write_en`=1.
- Multi-cycle flush: FLUSH_CYCLES=3, `branch_taken_EX` pulse of 1 cycle.
  - Expect `flush`=1 for 3 consecutive cycles and `flush_cnt`=3.
- Branch under memory stall: `mem_busy`=1 for 4 cycles with `branch_taken_EX`=1 in the first.
  - Expect 4 stall cycles, then 1 flush cycle, with `stall_flush` and `flush` never overlapping.
- Priority: `branch_taken_EX` and `load_use` together.
  - Expect `flush`=1, `stall_flush`=0, `stall_cnt` unchanged.
- Reset mid-FLUSH and saturation:
  - Reset low in the 2nd cycle of FLUSH: all counters and state cleared.
  - With CNT_W=4, 20 stall cycles: `stall_cnt` holds at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Types and constants shared by the pipeline hazard controller.
//   - hazard_state_e : controller FSM states (RUN, FLUSH, MEM_WAIT)
//   - REG_ADDR_W     : width of an architectural register address
//   - REG_ZERO       : the hard-wired zero register, never a real producer
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hazard_state_e;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk    in  : clock, counts on posedge
//     reset  in  : asynchronous active-low clear
//     inc_en in  : count this cycle
//     count  out : current value (WIDTH bits)
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc_en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Sequences the IF/ID register, the PC and the ID/EX register: stalls on
//   load-use hazards and data-memory busy, squashes wrong-path fetches on
//   taken branches and jumps, and counts stall / flush cycles.
//   Ports:
//     clk, reset                 : clock, asynchronous active-low reset
//     Rs_ID, Rt_ID               : source registers of the ID instruction
//     Rd_EX, MemRead_EX          : destination / load flag of the EX instruction
//     branch_taken_EX, jump_ID   : control-flow redirect requests
//     mem_busy                   : data memory cannot complete this cycle
//     stall_flush, flush         : IF/ID hold / clear
//     pc_write_en, id_ex_bubble  : PC update enable, NOP into ID/EX
//     stall_cnt, flush_cnt       : saturating performance counters
module hazard_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] Rs_ID,
    input  logic [REG_ADDR_W-1:0] Rt_ID,
    input  logic [REG_ADDR_W-1:0] Rd_EX,
    input  logic                  MemRead_EX,
    input  logic                  branch_taken_EX,
    input  logic                  jump_ID,
    input  logic                  mem_busy,
    output logic                  stall_flush,
    output logic                  flush,
    output logic                  pc_write_en,
    output logic                  id_ex_bubble,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int FLUSH_W = 3;

    hazard_state_e        state, state_nxt;
    logic [FLUSH_W-1:0]   flush_left, flush_left_nxt;
    logic                 pending_flush, pending_nxt;
    logic                 load_use;
    logic                 run_eval;
    logic                 stall_c, flush_c, bubble_c, pc_we_c;

    assign load_use = MemRead_EX && (Rd_EX != REG_ZERO) &&
                      ((Rd_EX == Rs_ID) || (Rd_EX == Rt_ID));

    always_comb begin
        state_nxt      = state;
        flush_left_nxt = flush_left;
        pending_nxt    = pending_flush;
        stall_c        = 1'b0;
        flush_c        = 1'b0;
        bubble_c       = 1'b0;
        pc_we_c        = 1'b1;
        run_eval       = 1'b0;

        unique case (state)
            ST_RUN: run_eval = 1'b1;

            ST_FLUSH: begin
                // A memory stall preempts the flush burst; only a single
                // replay flush survives it.
                if (mem_busy) begin
                    stall_c     = 1'b1;
                    pc_we_c     = 1'b0;
                    state_nxt   = ST_MEM_WAIT;
                    pending_nxt = 1'b1;
                end else begin
                    flush_c        = 1'b1;
                    bubble_c       = 1'b1;
                    flush_left_nxt = flush_left - FLUSH_W'(1);
                    if (flush_left == FLUSH_W'(1)) begin
                        state_nxt = ST_RUN;
                    end
                end
            end

            ST_MEM_WAIT: begin
                if (mem_busy) begin
                    stall_c     = 1'b1;
                    pc_we_c     = 1'b0;
                    pending_nxt = pending_flush | branch_taken_EX;
                end else if (pending_flush) begin
                    flush_c     = 1'b1;
                    bubble_c    = 1'b1;
                    pending_nxt = 1'b0;
                    state_nxt   = ST_RUN;
                end else begin
                    // Memory released with nothing owed: act as RUN this cycle.
                    state_nxt = ST_RUN;
                    run_eval  = 1'b1;
                end
            end

            default: state_nxt = ST_RUN;
        endcase

        if (run_eval) begin
            if (mem_busy) begin
                stall_c     = 1'b1;
                pc_we_c     = 1'b0;
                state_nxt   = ST_MEM_WAIT;
                pending_nxt = branch_taken_EX;
            end else if (branch_taken_EX) begin
                flush_c  = 1'b1;
                bubble_c = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_nxt      = ST_FLUSH;
                    flush_left_nxt = FLUSH_W'(FLUSH_CYCLES - 1);
                end
            end else if (jump_ID) begin
                flush_c = 1'b1;
            end else if (load_use) begin
                stall_c  = 1'b1;
                pc_we_c  = 1'b0;
                bubble_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_RUN;
            flush_left    <= '0;
            pending_flush <= 1'b0;
        end else begin
            state         <= state_nxt;
            flush_left    <= flush_left_nxt;
            pending_flush <= pending_nxt;
        end
    end

    // While reset is held the pipeline must stay quiet but the PC free-runs.
    assign stall_flush  = reset & stall_c;
    assign flush        = reset & flush_c;
    assign id_ex_bubble = reset & bubble_c;
    assign pc_write_en  = ~reset | pc_we_c;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc_en (stall_flush),
        .count  (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc_en (flush),
        .count  (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] Rs_ID = '0, Rt_ID = '0, Rd_EX = '0;
    logic       MemRead_EX = 0, branch_taken_EX = 0, jump_ID = 0, mem_busy = 0;

    // instance 0: FLUSH_CYCLES=3, CNT_W=4 ; instance 1: defaults (1, 16)
    logic        sf_a, fl_a, pw_a, bb_a;
    logic [3:0]  sc_a, fc_a;
    logic        sf_b, fl_b, pw_b, bb_b;
    logic [15:0] sc_b, fc_b;

    hazard_ctrl_unit #(.FLUSH_CYCLES(3), .CNT_W(4)) u_a (
        .clk(clk), .reset(reset), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Rd_EX(Rd_EX),
        .MemRead_EX(MemRead_EX), .branch_taken_EX(branch_taken_EX), .jump_ID(jump_ID),
        .mem_busy(mem_busy), .stall_flush(sf_a), .flush(fl_a), .pc_write_en(pw_a),
        .id_ex_bubble(bb_a), .stall_cnt(sc_a), .flush_cnt(fc_a)
    );

    hazard_ctrl_unit u_b (
        .clk(clk), .reset(reset), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Rd_EX(Rd_EX),
        .MemRead_EX(MemRead_EX), .branch_taken_EX(branch_taken_EX), .jump_ID(jump_ID),
        .mem_busy(mem_busy), .stall_flush(sf_b), .flush(fl_b), .pc_write_en(pw_b),
        .id_ex_bubble(bb_b), .stall_cnt(sc_b), .flush_cnt(fc_b)
    );

    always #5 clk = ~clk;

    logic [3:0]  ctl_dut [2];
    logic [15:0] sc_dut  [2];
    logic [15:0] fc_dut  [2];
    assign ctl_dut[0] = {sf_a, fl_a, pw_a, bb_a};
    assign ctl_dut[1] = {sf_b, fl_b, pw_b, bb_b};
    assign sc_dut[0]  = {12'd0, sc_a};
    assign sc_dut[1]  = sc_b;
    assign fc_dut[0]  = {12'd0, fc_a};
    assign fc_dut[1]  = fc_b;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Next-cycle stimulus, applied by tick()
    logic [4:0] n_rs = 0, n_rt = 0, n_rd = 0;
    bit n_mr = 0, n_br = 0, n_jp = 0, n_mb = 0, n_rst = 1;

    // Reference model: 0 = running, 1 = extra flush burst, 2 = waiting on memory
    int fcyc [2] = '{3, 1};
    int cmax [2] = '{15, 65535};
    int m_mode [2] = '{0, 0};
    int m_left [2] = '{0, 0};
    bit m_pend [2] = '{0, 0};
    int m_sc   [2] = '{0, 0};
    int m_fc   [2] = '{0, 0};
    int x_mode [2], x_left [2];
    bit x_pend [2];
    bit e_st [2], e_fl [2], e_pw [2], e_bb [2];

    task automatic model_eval(input int k);
        bit lu, run_rules, st, fl, pw, bb;
        lu = n_mr && (n_rd != 0) && (n_rd == n_rs || n_rd == n_rt);
        if (!n_rst) begin
            m_mode[k] = 0; m_left[k] = 0; m_pend[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end
        x_mode[k] = m_mode[k]; x_left[k] = m_left[k]; x_pend[k] = m_pend[k];
        st = 0; fl = 0; pw = 1; bb = 0; run_rules = 0;
        if (m_mode[k] == 0) run_rules = 1;
        else if (m_mode[k] == 1) begin
            if (n_mb) begin st = 1; pw = 0; x_mode[k] = 2; x_pend[k] = 1; end
            else begin
                fl = 1; bb = 1; x_left[k] = m_left[k] - 1;
                if (x_left[k] == 0) x_mode[k] = 0;
            end
        end else begin
            if (n_mb) begin st = 1; pw = 0; x_pend[k] = m_pend[k] | n_br; end
            else if (m_pend[k]) begin fl = 1; bb = 1; x_pend[k] = 0; x_mode[k] = 0; end
            else begin x_mode[k] = 0; run_rules = 1; end
        end
        if (run_rules) begin
            if (n_mb) begin st = 1; pw = 0; x_mode[k] = 2; x_pend[k] = n_br; end
            else if (n_br) begin
                fl = 1; bb = 1;
                if (fcyc[k] > 1) begin x_mode[k] = 1; x_left[k] = fcyc[k] - 1; end
            end else if (n_jp) fl = 1;
            else if (lu) begin st = 1; pw = 0; bb = 1; end
        end
        if (!n_rst) begin st = 0; fl = 0; pw = 1; bb = 0; end
        e_st[k] = st; e_fl[k] = fl; e_pw[k] = pw; e_bb[k] = bb;
    endtask

    task automatic model_commit(input int k);
        if (n_rst) begin
            m_mode[k] = x_mode[k]; m_left[k] = x_left[k]; m_pend[k] = x_pend[k];
            if (e_st[k] && m_sc[k] < cmax[k]) m_sc[k]++;
            if (e_fl[k] && m_fc[k] < cmax[k]) m_fc[k]++;
        end
    endtask

    task automatic tick(input string tag);
        @(negedge clk);
        Rs_ID = n_rs; Rt_ID = n_rt; Rd_EX = n_rd; MemRead_EX = n_mr;
        branch_taken_EX = n_br; jump_ID = n_jp; mem_busy = n_mb; reset = n_rst;
        #1;
        for (int k = 0; k < 2; k++) begin
            model_eval(k);
            check_eq($sformatf("%s.ctl[%0d]", tag, k), 32'(ctl_dut[k]),
                     32'({e_st[k], e_fl[k], e_pw[k], e_bb[k]}));
            check_eq($sformatf("%s.scnt[%0d]", tag, k), 32'(sc_dut[k]), 32'(m_sc[k]));
            check_eq($sformatf("%s.fcnt[%0d]", tag, k), 32'(fc_dut[k]), 32'(m_fc[k]));
            check_eq($sformatf("%s.excl[%0d]", tag, k), 32'(ctl_dut[k][3] & ctl_dut[k][2]), 32'(0));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_commit(k);
    endtask

    task automatic quiet();
        n_rs = 0; n_rt = 0; n_rd = 0; n_mr = 0; n_br = 0; n_jp = 0; n_mb = 0; n_rst = 1;
    endtask

    task automatic do_reset();
        quiet(); n_rst = 0; tick("rst"); n_rst = 1;
    endtask

    task automatic idle(input int n, input string tag);
        quiet();
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        // Reset state: only pc_write_en high, counters clear
        do_reset();
        check_eq("rst_ctl_a", 32'(ctl_dut[0]), 32'h2);
        check_eq("rst_scnt_a", 32'(sc_a), 32'd0);
        idle(1, "idle");

        // Load-use on Rs
        quiet(); n_mr = 1; n_rd = 5; n_rs = 5; n_rt = 9;
        #1 tick("lu");
        idle(2, "lu_after");
        #2 check_eq("lu_scnt_b", 32'(sc_b), 32'd1);

        // Zero register is never a hazard
        quiet(); n_mr = 1; n_rd = 0; n_rt = 0; n_rs = 0;
        tick("zero");
        #2 check_eq("zero_scnt_b", 32'(sc_b), 32'd1);

        // Taken branch: 3 flush cycles on instance 0, 1 on instance 1
        do_reset();
        quiet(); n_br = 1; tick("br");
        idle(4, "br_after");
        #2 check_eq("br_fcnt_a", 32'(fc_a), 32'd3);
        check_eq("br_fcnt_b", 32'(fc_b), 32'd1);

        // Branch under a 4-cycle memory stall
        do_reset();
        quiet(); n_mb = 1; n_br = 1; tick("mb_br");
        quiet(); n_mb = 1;
        for (int i = 0; i < 3; i++) tick("mb_hold");
        idle(2, "mb_rel");
        #2 check_eq("mb_scnt_a", 32'(sc_a), 32'd4);
        check_eq("mb_fcnt_a", 32'(fc_a), 32'd1);

        // Branch and load-use together: flush wins
        do_reset();
        quiet(); n_br = 1; n_mr = 1; n_rd = 7; n_rs = 7; tick("prio");
        idle(3, "prio_after");
        #2 check_eq("prio_scnt_a", 32'(sc_a), 32'd0);
        check_eq("prio_fcnt_a", 32'(fc_a), 32'd3);

        // Reset during the second flush cycle
        do_reset();
        quiet(); n_br = 1; tick("rf_br");
        idle(1, "rf_f2");
        quiet(); n_rst = 0; tick("rf_rst");
        check_eq("rf_ctl_a", 32'(ctl_dut[0]), 32'h2);
        check_eq("rf_fcnt_a", 32'(fc_a), 32'd0);
        idle(2, "rf_after");

        // Saturation: 20 stall cycles on a 4-bit counter
        do_reset();
        quiet(); n_mb = 1;
        for (int i = 0; i < 20; i++) tick("sat");
        idle(1, "sat_rel");
        #2 check_eq("sat_scnt_a", 32'(sc_a), 32'd15);
        check_eq("sat_scnt_b", 32'(sc_b), 32'd20);

        // Randomised traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            n_rs  = 5'($urandom_range(0, 3));
            n_rt  = 5'($urandom_range(0, 3));
            n_rd  = 5'($urandom_range(0, 3));
            n_mr  = ($urandom_range(0, 1) == 1);
            n_br  = ($urandom_range(0, 5) == 0);
            n_jp  = ($urandom_range(0, 5) == 0);
            n_mb  = ($urandom_range(0, 3) == 0);
            n_rst = ($urandom_range(0, 49) != 0);
            tick("rnd");
        end
        idle(2, "end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
